nn_inference_ctrl: RTL
======================

# nn_inference_ctrl

Sequencing controller driving the 10-neuron neural-network datapath through its three-layer schedule: hidden layer 1, hidden layer 2, output layer. Accepts one 62-byte test sample from a host via valid/ready and holds it stable on the datapath input. Issues the datapath's layer select, start, activation and result-latch strobes, then returns the 8-bit class via a valid/ready result port. Sits between the host/testbench sample source and the datapath, as the initiator for the datapath's control interface.

## Interface
- `SAMPLE_W`, 496: sample width, 62 × 8-bit features.
- `LAYER_CYCLES`, 64: datapath cycles per hidden layer after `dp_start`; legal range 2..65535.
- `TIMEOUT_CYCLES`, 1024: output-layer watchdog limit; used only with the macro.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `smp_valid`  in  1  host sample offered.
- `smp_data`  in  SAMPLE_W  host sample.
- `smp_ready`  out  1  controller accepts a sample.
- `dp_test_data`  out  SAMPLE_W  registered sample to the datapath.
- `dp_state`  out  2  layer select: 00 = hidden 1, 01 = hidden 2, 10 = output.
- `dp_start`  out  1  one-cycle neuron start pulse.
- `dp_hidden`  out  1  1 = hidden-layer activation, 0 = output layer.
- `dp_ld1` / `dp_ld2`  out  1  one-cycle latch strobes for the layer-1 and layer-2 result registers.
- `dp_ready`  in  1  datapath output-layer done.
- `dp_class`  in  8  datapath class index.
- `res_valid`  out  1  result available.
- `res_class`  out  8  captured class.
- `res_err`  out  1  result produced by a timeout.
- `res_ready`  in  1  host consumes the result.
- `busy`  out  1  FSM is not in IDLE.

## Operation
- **Reset values.** All outputs reset to 0; `dp_test_data` resets to 0; the FSM resets to IDLE. A reset mid-operation aborts immediately, and any pending result is lost.
- **FSM states.** IDLE → L1_START → L1_WAIT → L2_START → L2_WAIT → OUT_START → OUT_WAIT → IDLE.
- **IDLE.** `smp_ready` = (IDLE && !`res_valid`). On `smp_valid && smp_ready`, capture `smp_data` into `dp_test_data` and go to L1_START.
- **L1_START.** `dp_state`=00, `dp_hidden`=1, `dp_start`=1. Load the down-counter with LAYER_CYCLES−1. Go to L1_WAIT.
- **L1_WAIT.** `dp_state`=00, `dp_hidden`=1. Decrement the counter each cycle. In the cycle the counter equals 0, assert `dp_ld1`=1 and go to L2_START.
- **L2_START / L2_WAIT.** Identical to layer 1, with `dp_state`=01 and `dp_ld2` on the final cycle.
- **OUT_START.** `dp_state`=10, `dp_hidden`=0, `dp_start`=1. `dp_ready` is ignored in this cycle.
- **OUT_WAIT.** `dp_state`=10, `dp_hidden`=0. On `dp_ready`=1: register `dp_class` into `res_class`, set `res_valid`=1, clear `res_err`, and go to IDLE.
- **Result hold.** `res_valid`, `res_class` and `res_err` hold until the cycle after `res_valid && res_ready`. A new sample cannot be accepted while `res_valid`=1.
- **Sample stability.** `dp_test_data` changes only on an accept.
- **Strobe exclusivity.** `dp_start`, `dp_ld1` and `dp_ld2` are registered outputs and are never high in the same cycle.
- **`busy`.** 1 in every state except IDLE.

## Timing
- Accept handshake at edge 0: L1_START occupies cycle 1, and `dp_ld1` is high in cycle LAYER_CYCLES+1.
- `dp_start` for layer 2 is in cycle LAYER_CYCLES+2, and `dp_ld2` is in cycle 2·LAYER_CYCLES+2.
- Output `dp_start` is in cycle 2·LAYER_CYCLES+3.
- `res_valid` rises one cycle after the first `dp_ready`=1 sampled in OUT_WAIT.
- Minimum sample-to-result latency is 2·LAYER_CYCLES+5 cycles.
- A result consumed at edge k allows `smp_ready`=1 in cycle k+1.

## Configuration
- **`NN_CTRL_TIMEOUT_EN` defined.** A counter runs in OUT_WAIT. If `dp_ready` is still 0 after TIMEOUT_CYCLES cycles, the block sets `res_valid`=1, `res_class`=8'hFF and `res_err`=1, and returns to IDLE.
- **`NN_CTRL_TIMEOUT_EN` undefined.** OUT_WAIT waits indefinitely. `res_err` is tied to 0 and no timeout counter is synthesized.

## Test plan
- **Reset:** LAYER_CYCLES=4, assert `rst` asynchronously mid-cycle → all outputs 0 immediately, `smp_ready`=1 after release.
- **Nominal run:** sample byte0=8'h11, `dp_ready` driven high 3 cycles after output `dp_start`, `dp_class`=8'd7 → `dp_start` in cycles 1, 6, 11; `dp_ld1` in cycle 5; `dp_ld2` in cycle 10; `dp_state` sequence 00/01/10; `res_valid`=1 with `res_class`=7 in cycle 15.
- **Result backpressure:** hold `res_ready`=0 for 10 cycles with `smp_valid`=1 → `smp_ready` stays 0 and `res_class` is stable. Release `res_ready` → next sample accepted one cycle later.
- **Stale ready:** `dp_ready`=1 during OUT_START only → no result. Assert it again in OUT_WAIT → result captured.
- **Reset mid-run:** pulse `rst` in L2_WAIT → no `dp_ld2`, no result, IDLE after release.
- **Timeout:** with `NN_CTRL_TIMEOUT_EN`, TIMEOUT_CYCLES=8, hold `dp_ready`=0 → `res_valid`=1, `res_class`=8'hFF, `res_err`=1 nine cycles after the output `dp_start`.

Source files
------------

// File: rtl/nn_inference_ctrl.sv
// Three-layer sequencing controller for the 10-neuron NN datapath: sample in, layer schedule, class out.
// Optional output-layer watchdog enabled by defining NN_CTRL_TIMEOUT_EN.
module nn_inference_ctrl #(
   parameter int SAMPLE_W       = 496,
   parameter int LAYER_CYCLES   = 64,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                clk,
   input  logic                rst,
   // host sample port
   input  logic                smp_valid,
   input  logic [SAMPLE_W-1:0] smp_data,
   output logic                smp_ready,
   // datapath control
   output logic [SAMPLE_W-1:0] dp_test_data,
   output logic [1:0]          dp_state,
   output logic                dp_start,
   output logic                dp_hidden,
   output logic                dp_ld1,
   output logic                dp_ld2,
   input  logic                dp_ready,
   input  logic [7:0]          dp_class,
   // host result port
   output logic                res_valid,
   output logic [7:0]          res_class,
   output logic                res_err,
   input  logic                res_ready,
   output logic                busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_L1_START,
      S_L1_WAIT,
      S_L2_START,
      S_L2_WAIT,
      S_OUT_START,
      S_OUT_WAIT
   } state_e;

   localparam logic [1:0] LSEL_H1  = 2'b00;
   localparam logic [1:0] LSEL_H2  = 2'b01;
   localparam logic [1:0] LSEL_OUT = 2'b10;

   localparam int              CNT_W      = 16;
   localparam logic [CNT_W-1:0] LAYER_LOAD = CNT_W'(LAYER_CYCLES - 1);

   if (LAYER_CYCLES < 2 || LAYER_CYCLES > 65535 || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("nn_inference_ctrl: parameter out of range");
   end

   state_e              state_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [SAMPLE_W-1:0] test_data_q;
   logic [1:0]          dp_state_q;
   logic                dp_start_q;
   logic                dp_hidden_q;
   logic                dp_ld1_q;
   logic                dp_ld2_q;
   logic                smp_ready_q;
   logic                busy_q;
   logic                res_valid_q;
   logic [7:0]          res_class_q;

`ifdef NN_CTRL_TIMEOUT_EN
   localparam int            TO_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYCLES - 1);

   logic [TO_W-1:0] to_cnt_q;
   logic            res_err_q;
`endif

   logic smp_fire;
   logic res_fire;

   assign smp_fire = smp_valid && smp_ready_q;
   assign res_fire = res_valid_q && res_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         // NOTE: the sample register is reset on purpose so the datapath sees a defined input after reset.
         test_data_q <= '0;
         dp_state_q  <= LSEL_H1;
         dp_start_q  <= 1'b0;
         dp_hidden_q <= 1'b0;
         dp_ld1_q    <= 1'b0;
         dp_ld2_q    <= 1'b0;
         smp_ready_q <= 1'b0;
         busy_q      <= 1'b0;
         res_valid_q <= 1'b0;
         res_class_q <= '0;
`ifdef NN_CTRL_TIMEOUT_EN
         to_cnt_q    <= '0;
         res_err_q   <= 1'b0;
`endif
      end else begin
         // NOTE: strobes default low with non-blocking assignments; a later assignment in this block wins.
         dp_start_q <= 1'b0;
         dp_ld1_q   <= 1'b0;
         dp_ld2_q   <= 1'b0;

         if (res_fire) begin
            res_valid_q <= 1'b0;
         end

         unique case (state_q)
            S_IDLE: begin
               if (smp_fire) begin
                  test_data_q <= smp_data;
                  state_q     <= S_L1_START;
                  dp_state_q  <= LSEL_H1;
                  dp_hidden_q <= 1'b1;
                  dp_start_q  <= 1'b1;
                  busy_q      <= 1'b1;
                  smp_ready_q <= 1'b0;
               end else begin
                  smp_ready_q <= !(res_valid_q && !res_ready);
               end
            end

            S_L1_START: begin
               cnt_q   <= LAYER_LOAD;
               state_q <= S_L1_WAIT;
            end

            S_L1_WAIT: begin
               if (cnt_q == '0) begin
                  state_q    <= S_L2_START;
                  dp_state_q <= LSEL_H2;
                  dp_start_q <= 1'b1;
               end else begin
                  cnt_q    <= cnt_q - CNT_W'(1);
                  // Registered strobe: raised one edge early so it is high while the count reads zero.
                  dp_ld1_q <= (cnt_q == CNT_W'(1));
               end
            end

            S_L2_START: begin
               cnt_q   <= LAYER_LOAD;
               state_q <= S_L2_WAIT;
            end

            S_L2_WAIT: begin
               if (cnt_q == '0) begin
                  state_q     <= S_OUT_START;
                  dp_state_q  <= LSEL_OUT;
                  dp_hidden_q <= 1'b0;
                  dp_start_q  <= 1'b1;
               end else begin
                  cnt_q    <= cnt_q - CNT_W'(1);
                  dp_ld2_q <= (cnt_q == CNT_W'(1));
               end
            end

            S_OUT_START: begin
               // dp_ready may still be high from a previous sample, so it is not looked at here.
               state_q <= S_OUT_WAIT;
`ifdef NN_CTRL_TIMEOUT_EN
               to_cnt_q <= TO_LOAD;
`endif
            end

            S_OUT_WAIT: begin
               if (dp_ready) begin
                  res_class_q <= dp_class;
                  res_valid_q <= 1'b1;
                  state_q     <= S_IDLE;
                  dp_state_q  <= LSEL_H1;
                  busy_q      <= 1'b0;
`ifdef NN_CTRL_TIMEOUT_EN
                  res_err_q   <= 1'b0;
               end else if (to_cnt_q == '0) begin
                  res_class_q <= 8'hFF;
                  res_err_q   <= 1'b1;
                  res_valid_q <= 1'b1;
                  state_q     <= S_IDLE;
                  dp_state_q  <= LSEL_H1;
                  busy_q      <= 1'b0;
               end else begin
                  to_cnt_q <= to_cnt_q - TO_W'(1);
`endif
               end
            end

            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign smp_ready    = smp_ready_q;
   assign dp_test_data = test_data_q;
   assign dp_state     = dp_state_q;
   assign dp_start     = dp_start_q;
   assign dp_hidden    = dp_hidden_q;
   assign dp_ld1       = dp_ld1_q;
   assign dp_ld2       = dp_ld2_q;
   assign res_valid    = res_valid_q;
   assign res_class    = res_class_q;
   assign busy         = busy_q;

`ifdef NN_CTRL_TIMEOUT_EN
   assign res_err = res_err_q;
`else
   assign res_err = 1'b0;
`endif

   a_strobe_onehot: assert property (@(posedge clk) disable iff (rst)
      $onehot0({dp_start_q, dp_ld1_q, dp_ld2_q}));

endmodule
